// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: state encoding,
// lane strobe helper and elaboration-time parameter check.
package sram_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS,
        HOLD   = ST_HOLD
    } state_t;

    // Active-high mask of the byte lane addressed by byte-address bit 0.
    function automatic logic [1:0] lane_sel(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

    function automatic bit params_ok(
        input int channels,
        input int addr_w,
        input int wait_cycles,
        input int rr_mode
    );
        return (channels >= 2) && (channels <= 8) &&
               (addr_w >= 1) && (addr_w <= 30) &&
               (wait_cycles >= 1) && (wait_cycles <= 15) &&
               ((rr_mode == 0) || (rr_mode == 1));
    endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational request picker: fixed priority (lowest index)
// or round-robin starting just after the previous owner.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    last_grant,
    input  logic                rr_mode,
    output logic [CHANNELS-1:0] winner,
    output logic                valid
);

    int               start;
    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sel    = '0;
        start  = rr_mode ? int'(last_grant) + 1 : 0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel = IDX_W'((start + i) % CHANNELS);
            if (!found && req[sel]) begin
                winner[sel] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/sram_arb.sv
// Arbiter and timing sequencer for one shared asynchronous 16-bit
// SRAM with byte lanes, serving CHANNELS byte-wide requestors.
module sram_arb #(
    parameter int CHANNELS    = 4,
    parameter int ADDR_W      = 21,
    parameter int WAIT_CYCLES = 2,
    parameter int RR_MODE     = 0
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [CHANNELS-1:0]            REQ,
    input  logic [CHANNELS-1:0]            WE,
    input  logic [CHANNELS*(ADDR_W+1)-1:0] ADDR,
    input  logic [CHANNELS*8-1:0]          WDATA,
    output logic [CHANNELS-1:0]            ACK,
    output logic [7:0]                     RDATA,
    output logic [CHANNELS-1:0]            GRANT,
    output logic                           BUSY,
    output logic [ADDR_W-1:0]              MA,
    input  logic [15:0]                    MD_I,
    output logic [15:0]                    MD_O,
    output logic                           MD_OE,
    output logic [1:0]                     MRD_N,
    output logic [1:0]                     MWR_N
);

    import sram_arb_pkg::*;

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int AW1   = ADDR_W + 1;

    if (!params_ok(CHANNELS, ADDR_W, WAIT_CYCLES, RR_MODE)) begin : g_bad_params
        $error("sram_arb: parameter out of range");
    end

    state_t              state, state_d;
    logic [3:0]          cnt, cnt_d;
    logic [IDX_W-1:0]    last_grant, last_grant_d, win_idx;
    logic                we_q, we_d, lane_q, lane_d;
    logic [CHANNELS-1:0] grant_d, ack_d, winner;
    logic                win_valid;
    logic [7:0]          rdata_d;
    logic [ADDR_W-1:0]   ma_d;
    logic [15:0]         md_o_d;
    logic                md_oe_d;
    logic [1:0]          mrd_d, mwr_d, rd_lo, wr_lo;
    logic [ADDR_W:0]     addr_ch [CHANNELS];
    logic [7:0]          wdata_ch [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign addr_ch[i]  = ADDR[i*AW1 +: AW1];
        assign wdata_ch[i] = WDATA[i*8 +: 8];
    end

    rr_pick #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req        (REQ),
        .last_grant (last_grant),
        .rr_mode    (RR_MODE != 0),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner[i]) win_idx = IDX_W'(i);
        end
    end

    assign BUSY  = (state != IDLE);
    assign rd_lo = we_q ? 2'b11 : ~lane_sel(lane_q);
    assign wr_lo = we_q ? ~lane_sel(lane_q) : 2'b11;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        last_grant_d = last_grant;
        we_d         = we_q;
        lane_d       = lane_q;
        grant_d      = GRANT;
        ack_d        = '0;
        rdata_d      = RDATA;
        ma_d         = MA;
        md_o_d       = MD_O;
        md_oe_d      = MD_OE;
        mrd_d        = 2'b11;
        mwr_d        = 2'b11;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    state_d      = SETUP;
                    grant_d      = winner;
                    last_grant_d = win_idx;
                    we_d         = WE[win_idx];
                    lane_d       = addr_ch[win_idx][0];
                    ma_d         = addr_ch[win_idx][ADDR_W:1];
                    md_o_d       = {2{wdata_ch[win_idx]}};
                    md_oe_d      = WE[win_idx];
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_CYCLES - 1);
                mrd_d   = rd_lo;
                mwr_d   = wr_lo;
            end
            ACCESS: begin
                // Strobes rise on the same edge that captures read data.
                if (cnt == 4'd0) begin
                    state_d = HOLD;
                    ack_d   = GRANT;
                    if (!we_q) rdata_d = lane_q ? MD_I[15:8] : MD_I[7:0];
                end else begin
                    cnt_d = cnt - 4'd1;
                    mrd_d = rd_lo;
                    mwr_d = wr_lo;
                end
            end
            HOLD: begin
                state_d = IDLE;
                grant_d = '0;
                md_oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= IDX_W'(CHANNELS - 1);
            we_q       <= 1'b0;
            lane_q     <= 1'b0;
            GRANT      <= '0;
            ACK        <= '0;
            RDATA      <= '0;
            MA         <= '0;
            MD_O       <= '0;
            MD_OE      <= 1'b0;
            MRD_N      <= 2'b11;
            MWR_N      <= 2'b11;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            last_grant <= last_grant_d;
            we_q       <= we_d;
            lane_q     <= lane_d;
            GRANT      <= grant_d;
            ACK        <= ack_d;
            RDATA      <= rdata_d;
            MA         <= ma_d;
            MD_O       <= md_o_d;
            MD_OE      <= md_oe_d;
            MRD_N      <= mrd_d;
            MWR_N      <= mwr_d;
        end
    end

endmodule

// File: doc/sram_arb.md
# sram_arb

Parametrised arbiter and timing sequencer sharing one asynchronous 16-bit SRAM, with byte lanes, between CHANNELS byte-wide requestors: MCU ROM loader, MCU file loader, CPU and future DMA/video. It sits between the requestors and the top-level SRAM pins and replaces the priority-mux address/strobe scheme in the ALF top level. It adds fixed or round-robin arbitration, per-lane read and write strobes, programmable access length and registered read data.

## Interface
- CHANNELS, 4: number of requestors, 2..8.
- ADDR_W, 21: SRAM word-address width; channel byte address is ADDR_W+1 bits.
- WAIT_CYCLES, 2: cycles the strobe is held low per access, 1..15.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  CHANNELS  per-channel request, level.
- WE  in  CHANNELS  per-channel 1 = write, 0 = read.
- ADDR  in  CHANNELS*(ADDR_W+1)  per-channel byte address; bit 0 is the lane.
- WDATA  in  CHANNELS*8  per-channel write byte.
- ACK  out  CHANNELS  one-cycle completion pulse, one-hot.
- RDATA  out  8  read byte, valid while ACK is high and held until the next read completes.
- GRANT  out  CHANNELS  one-hot owner of the current access; 0 when idle.
- BUSY  out  1  high in any state other than IDLE.
- MA  out  ADDR_W  SRAM word address.
- MD_I  in  16  SRAM data in; the tristate buffer is in the top level.
- MD_O  out  16  write data, {WDATA, WDATA}.
- MD_OE  out  1  drive enable for MD.
- MRD_N  out  2  per-lane read strobe, active low; [0] = even byte.
- MWR_N  out  2  per-lane write strobe, active low.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if any REQ bit is high, register the winner into GRANT and latch its ADDR, WE and WDATA, then go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): MA and MD_O are valid and all strobes are high. MD_OE = 1 if the access is a write.
- ACCESS (WAIT_CYCLES cycles, down-counter): the selected lane strobe is low; MRD_N for a read, MWR_N for a write. The other lane stays high.
- HOLD (1 cycle): all strobes are high and MD_OE stays as in SETUP, which gives write data hold. ACK[grant] = 1, then go to IDLE.
- Read data: on the last ACCESS cycle, latch MD_I[7:0] into RDATA when lane = 0, or MD_I[15:8] when lane = 1.
- Fixed priority: the lowest set REQ index wins.
- Round-robin: the search starts at last_grant+1 modulo CHANNELS. last_grant updates on each grant.
- Requestor rule: ADDR, WE and WDATA are sampled once, at grant. REQ must be low in the cycle after ACK unless the requestor wants another access. A REQ still high in that cycle is treated as a new request.
- Reset values (asynchronous):
  - state = IDLE; GRANT, ACK and BUSY = 0.
  - MRD_N and MWR_N = 2'b11; MD_OE = 0; MA, MD_O and RDATA = 0.
  - last_grant = CHANNELS-1, so channel 0 is served first.
- Reset during an access aborts it immediately. Strobes go high in the same instant and no ACK is issued.
- Invalid parameter values are caught by an elaboration-time check.

## Timing
- Edge 0 is the edge on which IDLE sees REQ. Counting from edge 0:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycles 2..WAIT_CYCLES+1.
  - HOLD, with ACK, is cycle WAIT_CYCLES+2.
  - IDLE is cycle WAIT_CYCLES+3.
- Latency from REQ to ACK is WAIT_CYCLES+2 cycles. Peak throughput is one access per WAIT_CYCLES+3 cycles.
- All SRAM outputs are registered, so MA, MD_O, MD_OE and the strobes are glitch-free.
- Strobes are never low in SETUP or HOLD. At least one high cycle separates strobe pulses of consecutive accesses.
- Requests arriving during SETUP, ACCESS or HOLD are not sampled until the next IDLE.
- If REQ drops during an access, the access still completes and ACK still pulses.

## Structure
- Package sram_arb_pkg holds:
  - the state encoding localparams (IDLE=0, SETUP=1, ACCESS=2, HOLD=3);
  - the lane-select helper;
  - the parameter range-check function.
- Sub-module rr_pick: combinational, parametrised CHANNELS. Inputs are REQ, last_grant and RR_MODE; outputs are a one-hot winner and a valid flag. It is reused by the later video/DMA arbiter.
- Top level: the FSM, the wait counter, the latched request fields and the output registers.

## Test plan
- Single read: WAIT_CYCLES=2, ch1 reads byte address 0x00003 with MD_I=0xA55A.
  - MA=0x00001.
  - MRD_N=2'b01 for cycles 2-3 only.
  - ACK=4'b0010 in cycle 4.
  - RDATA=0xA5.
- Single write: ch0 writes 0x3C to address 0x00000.
  - MD_OE high in cycles 1-4.
  - MD_O=0x3C3C.
  - MWR_N=2'b10 in cycles 2-3 only.
  - MRD_N stays 2'b11.
- Fixed priority: REQ=4'b1110 held continuously with RR_MODE=0.
  - Grants are ch1, ch1, ch1 …
  - ch2 and ch3 starve.
- Round-robin: REQ=4'b1111 held with RR_MODE=1.
  - Grant order is 0, 1, 2, 3, 0.
  - Exactly one ACK every 5 cycles.
- Reset mid-operation: assert RESET in cycle 2 of a write.
  - MWR_N=2'b11 and MD_OE=0 asynchronously.
  - No ACK.
  - After release, the first grant goes to ch0.
- Slow timing with re-request: WAIT_CYCLES=15, ch2 holds REQ across its ACK.
  - A second access starts.
  - The second ACK arrives exactly 18 cycles after the first.
